// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches an operand, then performs one single-bit
// logical/arithmetic/rotate pass per clock and reports the result with a done pulse.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             shift_out_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               shout_q, shout_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   pass_val;
  logic               pass_out;
  logic               fill;

  // One single-position pass of the working register (the shifting_mid stage).
  always_comb begin
    fill     = 1'b0;
    pass_val = work_q;
    pass_out = 1'b0;
    if (!dir_q) begin
      fill     = (mode_q == 2'b10) ? work_q[WIDTH-1] : 1'b0;
      pass_val = {work_q[WIDTH-2:0], fill};
      pass_out = work_q[WIDTH-1];
    end else begin
      case (mode_q)
        2'b01:   fill = work_q[WIDTH-1];
        2'b10:   fill = work_q[0];
        default: fill = 1'b0;
      endcase
      pass_val = {fill, work_q[WIDTH-1:1]};
      pass_out = work_q[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    work_d   = work_q;
    result_d = result_q;
    shout_d  = shout_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dir_d   = dir_i;
          mode_d  = mode_i;
          work_d  = data_in_i;
          cnt_d   = amount_i;
          shout_d = 1'b0;
          if (amount_i == '0) begin
            state_d  = DONE;
            result_d = data_in_i;
            zero_d   = (data_in_i == '0);
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = pass_val;
        shout_d = pass_out;
        cnt_d   = cnt_q - AMT_W'(1);
        // Result is published on entry to DONE so it is valid alongside the pulse.
        if (cnt_q == AMT_W'(1)) begin
          state_d  = DONE;
          result_d = pass_val;
          zero_d   = (pass_val == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 2'b00;
      work_q   <= '0;
      result_q <= '0;
      shout_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      work_q   <= work_d;
      result_q <= result_d;
      shout_q  <= shout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign result_o    = result_q;
  assign shift_out_o = shout_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, latencies and handshake checks.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  amount = 4'd0;
  logic [15:0] data_in = 16'h0000;
  logic        busy, done, shift_out, zero;
  logic [15:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir), .mode_i(mode),
    .amount_i(amount), .data_in_i(data_in), .busy_o(busy), .done_o(done),
    .result_o(result), .shift_out_o(shift_out), .zero_o(zero)
  );

  // Accepts an operation at the next rising edge, then scrambles the inputs.
  task automatic issue(input logic [15:0] d, input logic dr, input logic [1:0] m,
                       input logic [3:0] a);
    @(negedge clk);
    data_in = d; dir = dr; mode = m; amount = a; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; data_in = ~d; dir = ~dr; mode = ~m; amount = ~a;
  endtask

  // Returns the cycle index (accept edge = cycle 0) at which done is seen, or -1.
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset_values;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_result got=%h exp=0000", result); end
    total++; if (shift_out !== 1'b0) begin bad++; $display("FAIL rst_shout got=%b exp=0", shift_out); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", zero); end
    rst = 1'b0;
  endtask

  task automatic test_left_logical;
    int lat;
    issue(16'h8001, 1'b0, 2'b00, 4'd1);
    wait_done(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL t2_latency got=%0d exp=2", lat); end
    total++; if (result !== 16'h0002) begin bad++; $display("FAIL t2_result got=%h exp=0002", result); end
    total++; if (shift_out !== 1'b1) begin bad++; $display("FAIL t2_shout got=%b exp=1", shift_out); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL t2_zero got=%b exp=0", zero); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t2_after got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_reset_mid_shift;
    int doneCnt;
    issue(16'h8000, 1'b1, 2'b01, 4'd15);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done got=%b exp=0", done); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL t1_result got=%h exp=0000", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL t1_zero got=%b exp=1", zero); end
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    total++; if (doneCnt !== 0) begin bad++; $display("FAIL t1_no_done got=%0d exp=0", doneCnt); end
  endtask

  task automatic test_right_arith_max;
    int lat;
    issue(16'h8000, 1'b1, 2'b01, 4'd15);
    wait_done(lat);
    total++; if (lat !== 16) begin bad++; $display("FAIL t3_latency got=%0d exp=16", lat); end
    total++; if (result !== 16'hFFFF) begin bad++; $display("FAIL t3_result got=%h exp=ffff", result); end
    total++; if (shift_out !== 1'b0) begin bad++; $display("FAIL t3_shout got=%b exp=0", shift_out); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL t3_zero got=%b exp=0", zero); end
  endtask

  task automatic test_rotate_and_zero_amount;
    int lat;
    issue(16'h00F1, 1'b1, 2'b10, 4'd4);
    wait_done(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL t4_latency got=%0d exp=5", lat); end
    total++; if (result !== 16'h100F) begin bad++; $display("FAIL t4_result got=%h exp=100f", result); end
    total++; if (shift_out !== 1'b0) begin bad++; $display("FAIL t4_shout got=%b exp=0", shift_out); end
    // Leave shift_out high so the amount=0 case must clear it.
    issue(16'h8001, 1'b0, 2'b10, 4'd1);
    wait_done(lat);
    total++; if (result !== 16'h0003 || shift_out !== 1'b1) begin bad++; $display("FAIL rotl_result got=%h/%b exp=0003/1", result, shift_out); end
    issue(16'h00F1, 1'b1, 2'b10, 4'd0);
    wait_done(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL t4_amt0_latency got=%0d exp=1", lat); end
    total++; if (result !== 16'h00F1) begin bad++; $display("FAIL t4_amt0_result got=%h exp=00f1", result); end
    total++; if (shift_out !== 1'b0) begin bad++; $display("FAIL t4_amt0_shout got=%b exp=0", shift_out); end
    issue(16'h8001, 1'b0, 2'b11, 4'd2);
    wait_done(lat);
    total++; if (result !== 16'h0004 || shift_out !== 1'b0) begin bad++; $display("FAIL mode11_result got=%h/%b exp=0004/0", result, shift_out); end
  endtask

  task automatic test_start_while_busy;
    int doneCnt;
    logic [15:0] seen;
    logic seenZero, seenOut;
    issue(16'h0001, 1'b1, 2'b00, 4'd1);
    doneCnt = 0; seen = 16'hDEAD; seenZero = 1'b0; seenOut = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        doneCnt++; seen = result; seenZero = zero; seenOut = shift_out;
      end
      if (i == 0) begin
        start = 1'b1; data_in = 16'hFFFF; amount = 4'd3; dir = 1'b0;
      end else if (i == 1) begin
        start = 1'b0;
      end
    end
    total++; if (doneCnt !== 1) begin bad++; $display("FAIL t5_done_count got=%0d exp=1", doneCnt); end
    total++; if (seen !== 16'h0000) begin bad++; $display("FAIL t5_result got=%h exp=0000", seen); end
    total++; if (seenZero !== 1'b1) begin bad++; $display("FAIL t5_zero got=%b exp=1", seenZero); end
    total++; if (seenOut !== 1'b1) begin bad++; $display("FAIL t5_shout got=%b exp=1", seenOut); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int holdErr;
    issue(16'h0F00, 1'b0, 2'b00, 4'd4);
    wait_done(lat);
    total++; if (result !== 16'hF000) begin bad++; $display("FAIL t6_first got=%h exp=f000", result); end
    // Next negedge is the IDLE cycle right after DONE.
    @(negedge clk);
    data_in = 16'h0F00; dir = 1'b1; mode = 2'b01; amount = 4'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; data_in = 16'h1234;
    holdErr = 0;
    lat = 1;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_accept got=%b exp=1", busy); end
    while (!done && lat < 40) begin
      if (result !== 16'hF000) holdErr++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    total++; if (holdErr !== 0) begin bad++; $display("FAIL t6_hold got=%0d exp=0", holdErr); end
    total++; if (lat !== 3) begin bad++; $display("FAIL t6_latency got=%0d exp=3", lat); end
    total++; if (result !== 16'h03C0) begin bad++; $display("FAIL t6_second got=%h exp=03c0", result); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset_values();
    test_left_logical();
    test_reset_mid_shift();
    test_right_arith_max();
    test_rotate_and_zero_amount();
    test_start_while_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
